// File: rtl/bitfusion_pkg.sv
// Shared types and helpers for the bitfusion wavefront sequencer.
package bitfusion_pkg;

    localparam logic [2:0] BW_2B = 3'b001;
    localparam logic [2:0] BW_4B = 3'b010;
    localparam logic [2:0] BW_8B = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } wf_state_t;

    // Beats per 32-bit word: only an 8-bit operand needs two passes.
    function automatic logic [1:0] beats_of(input logic [2:0] in_bw, input logic [2:0] wt_bw);
        if ((in_bw == BW_8B) || (wt_bw == BW_8B)) begin
            beats_of = 2'd2;
        end else begin
            beats_of = 2'd1;
        end
    endfunction

    function automatic logic bw_valid(input logic [2:0] bw);
        case (bw)
            BW_2B, BW_4B, BW_8B: bw_valid = 1'b1;
            default:             bw_valid = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/bitfusion_wavefront_ctrl.sv
// Sequencer producing the staggered read-enable wavefront for a ROWS x COLS
// bitfusion array: clear, run the skewed window, drain the pipe, then signal done.
module bitfusion_wavefront_ctrl
    import bitfusion_pkg::*;
#(
    parameter  int ROWS     = 2,
    parameter  int COLS     = 2,
    parameter  int MAX_K    = 256,
    parameter  int PIPE_LAT = 2,
    localparam int KW_W     = $clog2(MAX_K + 1)
) (
    input  logic                   clk,
    input  logic                   nRST,
    input  logic                   start,
    input  logic                   abort,
    input  logic [KW_W-1:0]        k_words,
    input  logic [2:0]             input_bitwidth,
    input  logic [2:0]             weight_bitwidth,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [ROWS-1:0]        acc_clear,
    output logic [ROWS-1:0]        input_rd_en,
    output logic [ROWS*COLS-1:0]   weight_rd_en,
    output logic [ROWS-1:0]        input_beat,
    output logic [ROWS-1:0]        input_word_adv
);

    localparam int T_W = $clog2(MAX_K * 2 + ROWS + COLS);
    localparam logic [T_W-1:0] DRAIN_LAST = T_W'((PIPE_LAT > 0) ? (PIPE_LAT - 1) : 0);
    localparam logic [T_W-1:0] SKEW       = T_W'(ROWS + COLS - 2);

    wf_state_t              state_r;
    wf_state_t              state_nx_s;
    logic [T_W-1:0]         t_r;
    logic [T_W-1:0]         t_nx_s;
    logic [T_W-1:0]         len_r;
    logic [T_W-1:0]         trun_s;
    logic                   dbl_r;
    logic                   cfg_ok_s;
    logic                   accept_s;
    logic                   run_nx_s;
    logic [ROWS*COLS-1:0]   win_s;
    logic [ROWS-1:0]        row_en_s;
    logic [ROWS-1:0]        row_beat_s;
    logic [ROWS-1:0]        row_adv_s;

    assign cfg_ok_s = (k_words != {KW_W{1'b0}}) && (k_words <= KW_W'(MAX_K)) &&
                      bw_valid(input_bitwidth) && bw_valid(weight_bitwidth);
    assign accept_s = (state_r == ST_IDLE) && start && cfg_ok_s;
    assign trun_s   = len_r + SKEW;
    assign run_nx_s = (state_nx_s == ST_RUN);

    // Next state and counter; t doubles as the drain counter.
    always_comb begin
        state_nx_s = state_r;
        t_nx_s     = {T_W{1'b0}};
        if (abort && (state_r != ST_IDLE)) begin
            state_nx_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_nx_s = ST_CLEAR;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_CLEAR: state_nx_s = ST_RUN;
                ST_RUN: begin
                    if (t_r == (trun_s - T_W'(1))) begin
                        state_nx_s = (PIPE_LAT == 0) ? ST_DONE : ST_DRAIN;
                    end else begin
                        t_nx_s = t_r + T_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (t_r == DRAIN_LAST) begin
                        state_nx_s = ST_DONE;
                    end else begin
                        t_nx_s = t_r + T_W'(1);
                    end
                end
                ST_DONE: state_nx_s = ST_IDLE;
                default: state_nx_s = ST_IDLE;
            endcase
        end
    end

    // Windows are evaluated on the next-cycle t so the registered enables line up with RUN.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            localparam logic [T_W-1:0] OFS = T_W'(r + c);
            assign win_s[r*COLS+c] = (t_nx_s >= OFS) && (t_nx_s < (OFS + len_r));
        end
        localparam logic ODD = 1'((r % 2) != 0);
        assign row_en_s[r]   = win_s[r*COLS];
        assign row_beat_s[r] = row_en_s[r] & dbl_r & (t_nx_s[0] ^ ODD);
        assign row_adv_s[r]  = row_en_s[r] & (~dbl_r | row_beat_s[r]);
    end

    // State, latched job config and registered outputs.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_r        <= ST_IDLE;
            t_r            <= {T_W{1'b0}};
            len_r          <= {T_W{1'b0}};
            dbl_r          <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            acc_clear      <= {ROWS{1'b0}};
            input_rd_en    <= {ROWS{1'b0}};
            weight_rd_en   <= {(ROWS*COLS){1'b0}};
            input_beat     <= {ROWS{1'b0}};
            input_word_adv <= {ROWS{1'b0}};
        end else begin
            state_r <= state_nx_s;
            t_r     <= t_nx_s;
            if (accept_s) begin
                dbl_r <= (beats_of(input_bitwidth, weight_bitwidth) == 2'd2);
                if (beats_of(input_bitwidth, weight_bitwidth) == 2'd2) begin
                    len_r <= T_W'({k_words, 1'b0});
                end else begin
                    len_r <= T_W'(k_words);
                end
            end
            busy           <= (state_nx_s != ST_IDLE);
            done           <= (state_nx_s == ST_DONE);
            err            <= (state_r == ST_IDLE) && start && !cfg_ok_s;
            acc_clear      <= {ROWS{state_nx_s == ST_CLEAR}};
            weight_rd_en   <= run_nx_s ? win_s      : {(ROWS*COLS){1'b0}};
            input_rd_en    <= run_nx_s ? row_en_s   : {ROWS{1'b0}};
            input_beat     <= run_nx_s ? row_beat_s : {ROWS{1'b0}};
            input_word_adv <= run_nx_s ? row_adv_s  : {ROWS{1'b0}};
        end
    end

endmodule

// File: tb/tb_bitfusion_wavefront_ctrl.sv
// Bench: two sequencer instances (2x2 with drain, 4x3 without) checked every cycle
// against a job-timeline model, plus literal waveform pins.
module tb_bitfusion_wavefront_ctrl;

    localparam int RS[2] = '{2, 4};
    localparam int CS[2] = '{2, 3};
    localparam int PS[2] = '{2, 0};
    localparam int MAXK  = 256;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        err;
        logic [15:0] acc;
        logic [15:0] ien;
        logic [15:0] w;
        logic [15:0] beat;
        logic [15:0] adv;
    } exp_t;

    logic       clk = 1'b0;
    logic       nRST = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [8:0] k_words = 9'd1;
    logic [2:0] ibw = 3'b001;
    logic [2:0] wbw = 3'b001;

    logic busy_a, done_a, err_a, busy_b, done_b, err_b;
    logic [1:0]  acc_a, ien_a, beat_a, adv_a;
    logic [3:0]  w_a;
    logic [3:0]  acc_b, ien_b, beat_b, adv_b;
    logic [11:0] w_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bitfusion_wavefront_ctrl #(.ROWS(2), .COLS(2), .MAX_K(MAXK), .PIPE_LAT(2)) dut_a (
        .clk(clk), .nRST(nRST), .start(start), .abort(abort), .k_words(k_words),
        .input_bitwidth(ibw), .weight_bitwidth(wbw), .busy(busy_a), .done(done_a),
        .err(err_a), .acc_clear(acc_a), .input_rd_en(ien_a), .weight_rd_en(w_a),
        .input_beat(beat_a), .input_word_adv(adv_a));

    bitfusion_wavefront_ctrl #(.ROWS(4), .COLS(3), .MAX_K(MAXK), .PIPE_LAT(0)) dut_b (
        .clk(clk), .nRST(nRST), .start(start), .abort(abort), .k_words(k_words),
        .input_bitwidth(ibw), .weight_bitwidth(wbw), .busy(busy_b), .done(done_b),
        .err(err_b), .acc_clear(acc_b), .input_rd_en(ien_b), .weight_rd_en(w_b),
        .input_beat(beat_b), .input_word_adv(adv_b));

    exp_t obs0, obs1;
    assign obs0 = {busy_a, done_a, err_a, 16'(acc_a), 16'(ien_a), 16'(w_a), 16'(beat_a), 16'(adv_a)};
    assign obs1 = {busy_b, done_b, err_b, 16'(acc_b), 16'(ien_b), 16'(w_b), 16'(beat_b), 16'(adv_b)};

    // Model: per instance, whether a job is live, the cycle index within it, L and beats.
    bit mact[2];
    bit merr[2];
    int mk[2];
    int ml[2];
    int mb[2];

    function automatic int bits_of(input logic [2:0] bw);
        case (bw)
            3'b001:  return 2;
            3'b010:  return 4;
            default: return 8;
        endcase
    endfunction

    function automatic bit cfg_ok();
        return (k_words != 9'd0) && (int'(k_words) <= MAXK) &&
               ($countones(ibw) == 1) && ($countones(wbw) == 1);
    endfunction

    always @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < 2; i++) begin
                mact[i] = 1'b0;
                merr[i] = 1'b0;
                mk[i]   = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                int last;
                int bmax;
                last = ml[i] + RS[i] + CS[i] - 2 + PS[i] + 1;
                if (mact[i]) begin
                    merr[i] = 1'b0;
                    if (abort || (mk[i] == last)) mact[i] = 1'b0;
                    else mk[i] = mk[i] + 1;
                end else if (start) begin
                    if (cfg_ok()) begin
                        bmax    = (bits_of(ibw) > bits_of(wbw)) ? bits_of(ibw) : bits_of(wbw);
                        mb[i]   = (bmax / 4 < 1) ? 1 : bmax / 4;
                        ml[i]   = int'(k_words) * mb[i];
                        mk[i]   = 0;
                        mact[i] = 1'b1;
                        merr[i] = 1'b0;
                    end else begin
                        merr[i] = 1'b1;
                    end
                end else begin
                    merr[i] = 1'b0;
                end
            end
        end
    end

    function automatic exp_t model_exp(input int i);
        exp_t e;
        int   trun;
        int   t;
        int   bt;
        e    = '0;
        trun = ml[i] + RS[i] + CS[i] - 2;
        e.err = merr[i];
        if (mact[i]) begin
            e.busy = 1'b1;
            if (mk[i] == 0) e.acc = (16'd1 << RS[i]) - 16'd1;
            if (mk[i] == trun + PS[i] + 1) e.done = 1'b1;
            if (mk[i] >= 1 && mk[i] <= trun) begin
                t = mk[i] - 1;
                for (int r = 0; r < RS[i]; r++) begin
                    for (int c = 0; c < CS[i]; c++) begin
                        if (t >= r + c && t < r + c + ml[i]) e.w[r*CS[i]+c] = 1'b1;
                    end
                    if (t >= r && t < r + ml[i]) begin
                        bt          = (t - r) % mb[i];
                        e.ien[r]    = 1'b1;
                        e.beat[r]   = (bt != 0);
                        e.adv[r]    = (bt == mb[i] - 1);
                    end
                end
            end
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        exp_t e;
        exp_t o;
        for (int i = 0; i < 2; i++) begin
            e = model_exp(i);
            o = (i == 0) ? obs0 : obs1;
            chk($sformatf("u%0d_busy", i), 16'(o.busy), 16'(e.busy));
            chk($sformatf("u%0d_done", i), 16'(o.done), 16'(e.done));
            chk($sformatf("u%0d_err", i),  16'(o.err),  16'(e.err));
            chk($sformatf("u%0d_acc", i),  o.acc,  e.acc);
            chk($sformatf("u%0d_ien", i),  o.ien,  e.ien);
            chk($sformatf("u%0d_wen", i),  o.w,    e.w);
            chk($sformatf("u%0d_beat", i), o.beat, e.beat);
            chk($sformatf("u%0d_adv", i),  o.adv,  e.adv);
        end
    end

    // Issues a one-cycle start; returns in the middle of cycle 0 (CLEAR).
    task automatic go(input logic [8:0] k, input logic [2:0] ib, input logic [2:0] wb);
        @(negedge clk);
        k_words = k; ibw = ib; wbw = wb; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic reject(input string nm, input logic [8:0] k, input logic [2:0] wb);
        @(negedge clk);
        k_words = k; ibw = 3'b010; wbw = wb; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({nm, "_err"}, 16'(err_a), 16'd1);
        chk({nm, "_busy"}, 16'(busy_a), 16'd0);
        @(negedge clk);
        chk({nm, "_err_clr"}, 16'(err_b), 16'd0);
    endtask

    logic [3:0] tbl_w [8];
    logic [1:0] tbl_i [8];
    logic [1:0] tbl_3 [6];

    initial begin
        tbl_w = '{4'h0, 4'h1, 4'h7, 4'hE, 4'h8, 4'h0, 4'h0, 4'h0};
        tbl_i = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0};
        tbl_3 = '{2'd0, 2'd1, 2'd3, 2'd3, 2'd2, 2'd0};
        #2 nRST = 1'b0;
        #1 chk("rst_busy", 16'(busy_a), 16'd0);
        repeat (3) @(negedge clk);
        nRST = 1'b1;

        // 8b x 4b, one word: the reference wavefront.
        go(9'd1, 3'b100, 3'b010);
        for (int k = 0; k < 9; k++) begin
            if (k < 8) begin
                chk($sformatf("p1_wen_c%0d", k), 16'(w_a), 16'(tbl_w[k]));
                chk($sformatf("p1_ien_c%0d", k), 16'(ien_a), 16'(tbl_i[k]));
                chk($sformatf("p1_done_c%0d", k), 16'(done_a), 16'(k == 7));
            end
            if (k == 2) chk("p1_beat0_t1", 16'(beat_a[0]), 16'd1);
            if (k == 2) chk("p1_adv0_t1", 16'(adv_a[0]), 16'd1);
            chk($sformatf("p1b_done_c%0d", k), 16'(done_b), 16'(k == 8));
            @(negedge clk);
        end
        repeat (6) @(negedge clk);

        // 2b x 2b, three words: advance on every enabled beat.
        go(9'd3, 3'b001, 3'b001);
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("p2_acc_c%0d", k), 16'(acc_a), (k == 0) ? 16'd3 : 16'd0);
            if (k < 6) chk($sformatf("p2_adv_c%0d", k), 16'(adv_a), 16'(tbl_3[k]));
            chk($sformatf("p2_done_c%0d", k), 16'(done_a), 16'(k == 8));
            @(negedge clk);
        end
        repeat (6) @(negedge clk);

        // 4b x 8b, two words on the 4x3 array with no drain.
        go(9'd2, 3'b010, 3'b100);
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("p3_w32_c%0d", k), 16'(w_b[11]), 16'(k >= 6 && k <= 9));
            chk($sformatf("p3_done_c%0d", k), 16'(done_b), 16'(k == 10));
            @(negedge clk);
        end
        repeat (4) @(negedge clk);

        reject("rej_k0", 9'd0, 3'b001);
        reject("rej_bw", 9'd2, 3'b011);
        reject("rej_kbig", 9'd257, 3'b001);

        // Abort at t=1, then a normal job.
        go(9'd4, 3'b001, 3'b001);
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_busy", 16'(busy_a), 16'd0);
        chk("ab_wen", 16'(w_a), 16'd0);
        chk("ab_busy_b", 16'(busy_b), 16'd0);
        for (int k = 0; k < 10; k++) begin
            chk("ab_no_done", 16'(done_a), 16'd0);
            @(negedge clk);
        end
        go(9'd1, 3'b001, 3'b001);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("ab2_done_c%0d", k), 16'(done_a), 16'(k == 6));
            @(negedge clk);
        end
        repeat (4) @(negedge clk);

        // Start held while busy is ignored.
        go(9'd2, 3'b001, 3'b001);
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("sb_done_c7", 16'(done_a), 16'd1);
        @(negedge clk);
        chk("sb_idle_c8", 16'(busy_a), 16'd0);
        repeat (6) @(negedge clk);

        // Reset mid-RUN, then a clean one-word job.
        go(9'd4, 3'b100, 3'b100);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #2 nRST = 1'b0;
        #1;
        chk("rs_busy", 16'(busy_a), 16'd0);
        chk("rs_wen", 16'(w_a), 16'd0);
        chk("rs_ien_b", 16'(ien_b), 16'd0);
        @(negedge clk);
        @(negedge clk);
        nRST = 1'b1;
        go(9'd1, 3'b100, 3'b010);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("rs2_wen_c%0d", k), 16'(w_a), 16'(tbl_w[k]));
            chk($sformatf("rs2_done_c%0d", k), 16'(done_a), 16'(k == 7));
            @(negedge clk);
        end

        // Randomized traffic: legal and illegal configs, aborts, occasional resets.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            abort = ($urandom_range(0, 39) == 0);
            case ($urandom_range(0, 15))
                0:       k_words = 9'd0;
                1:       k_words = 9'(257 + $urandom_range(0, 200));
                default: k_words = 9'(1 + $urandom_range(0, 5));
            endcase
            ibw = 3'b001 << $urandom_range(0, 2);
            wbw = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : (3'b001 << $urandom_range(0, 2));
            if ($urandom_range(0, 499) == 0) begin
                #2 nRST = 1'b0;
                @(negedge clk);
                #2 nRST = 1'b1;
            end
        end
        start = 1'b0;
        abort = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
